// File: rtl/ap_prof_pkg.sv
// rtl/ap_prof_pkg.sv - shared types and widths for the transaction profiler
// Purpose: capture FSM state enum, profile record layout and default field widths.
// Ports: none (package).
package ap_prof_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_ITER_W = 16;
  localparam int DEF_TXN_W  = 16;
  localparam int REC_W      = DEF_TXN_W + 2 * DEF_CNT_W + DEF_ITER_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Field order matches rec_data, MSB first.
  typedef struct packed {
    logic [DEF_TXN_W-1:0]  txn_id;
    logic [DEF_CNT_W-1:0]  start_cycle;
    logic [DEF_CNT_W-1:0]  latency;
    logic [DEF_ITER_W-1:0] iters;
  } prof_rec_t;

endpackage

// File: rtl/ap_txn_profiler_if.sv
// rtl/ap_txn_profiler_if.sv - ap_ctrl_hs tap plus record stream bundle
// Purpose: groups the core handshake taps and the record output stream.
// Ports (slave = profiler side):
//   ap_start, ap_ready, ap_done, cur_state : core taps into the profiler
//   rec_valid, rec_data                    : record stream out of the profiler
//   rec_ready                              : consumer backpressure
interface ap_txn_profiler_if
  import ap_prof_pkg::*;
#(
  parameter int NUM_STATES = 6,
  parameter int RW         = REC_W
);
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic [NUM_STATES-1:0] cur_state;
  logic                  rec_valid;
  logic                  rec_ready;
  logic [RW-1:0]         rec_data;

  modport slave (
    input  ap_start, ap_ready, ap_done, cur_state, rec_ready,
    output rec_valid, rec_data
  );

  modport master (
    output ap_start, ap_ready, ap_done, cur_state, rec_ready,
    input  rec_valid, rec_data
  );
endinterface

// File: rtl/ap_prof_fifo.sv
// rtl/ap_prof_fifo.sv - first-word-fall-through record FIFO
// Purpose: buffers profile records; accepts a push while full if a pop happens
//          in the same cycle.
// Ports:
//   clock, reset       : clock, async active-high reset
//   push, wdata        : write request and record
//   rd_ready           : consumer accepts the head record
//   rd_valid, rd_data  : head record (rd_data reads 0 while empty)
//   drop               : pulse, a push was rejected because the FIFO was full
module ap_prof_fifo #(
  parameter int DEPTH = 8,
  parameter int REC_W = 96
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [REC_W-1:0] wdata,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        accept;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && rd_ready;
  assign accept   = push && (!full || pop);
  assign drop     = push && !accept;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full with a pop, the write lands in the slot being read out this
  // cycle; the read side sees the old entry combinationally before the edge.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ap_txn_profiler.sv
// rtl/ap_txn_profiler.sv - per-transaction latency/iteration profiler for ap_ctrl_hs cores
// Purpose: builds {txn_id, start_cycle, latency, iters} per transaction and
//          streams the records out through a FWFT FIFO.
// Ports:
//   clock, reset : clock, async active-high reset
//   bus          : ap_start/ap_ready/ap_done/cur_state taps, rec_* stream
//   finish       : stop capturing and drain
//   overflow     : sticky, a record was dropped
//   proto_err    : sticky, handshake violation seen
//   busy         : transaction in flight
//   drain_done   : finish seen and FIFO empty
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int NUM_STATES   = 6,
  parameter int ITER_END_IDX = 5,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int ITER_W       = DEF_ITER_W,
  parameter int TXN_W        = DEF_TXN_W,
  parameter int DEPTH        = 8
) (
  input  logic              clock,
  input  logic              reset,
  ap_txn_profiler_if.slave  bus,
  input  logic              finish,
  output logic              overflow,
  output logic              proto_err,
  output logic              busy,
  output logic              drain_done
);
  localparam int RW = TXN_W + 2 * CNT_W + ITER_W;

  state_t            state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  start_cycle;
  logic [ITER_W-1:0] iters;
  logic [TXN_W-1:0]  txn_id;
  logic              iter_q;

  logic              rise;
  logic [ITER_W-1:0] iters_inc;
  logic              push;
  logic              drop;
  logic [CNT_W-1:0]  rec_start;
  logic [CNT_W-1:0]  rec_lat;
  logic [ITER_W-1:0] rec_iters;
  logic [RW-1:0]     rec_in;

  always_comb begin
    rise      = bus.cur_state[ITER_END_IDX] & ~iter_q;
    iters_inc = (rise && (iters != '1)) ? iters + ITER_W'(1) : iters;

    // finish wins over a coincident ap_done: nothing is captured that cycle.
    push = 1'b0;
    if (!finish) begin
      if (state == IDLE)     push = bus.ap_start & bus.ap_done;
      else if (state == RUN) push = bus.ap_done;
    end

    // A start+done in IDLE is a one-cycle transaction starting right now.
    rec_start = (state == RUN) ? start_cycle : cycle_cnt;
    rec_iters = (state == RUN) ? iters_inc : '0;
    rec_lat   = cycle_cnt - rec_start + CNT_W'(1);
    rec_in    = {txn_id, rec_start, rec_lat, rec_iters};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cycle_cnt   <= '0;
      start_cycle <= '0;
      iters       <= '0;
      txn_id      <= '0;
      iter_q      <= 1'b0;
      overflow    <= 1'b0;
      proto_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      iter_q    <= bus.cur_state[ITER_END_IDX];
      if (drop) overflow <= 1'b1;
      // Dropped records still consume an id so gaps reveal the loss.
      if (push) txn_id <= txn_id + TXN_W'(1);

      if (finish) begin
        state <= DRAIN;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.ap_start && !bus.ap_done) begin
              state       <= RUN;
              busy        <= 1'b1;
              start_cycle <= cycle_cnt;
              iters       <= '0;
            end else if (bus.ap_done && !bus.ap_start) begin
              proto_err <= 1'b1;
            end
          end
          RUN: begin
            iters <= iters_inc;
            if (bus.ap_ready && !bus.ap_start) proto_err <= 1'b1;
            if (bus.ap_done) begin
              if (bus.ap_start) begin
                // Back-to-back: the next transaction starts on the following cycle.
                start_cycle <= cycle_cnt + CNT_W'(1);
                iters       <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic fifo_valid;

  ap_prof_fifo #(
    .DEPTH (DEPTH),
    .REC_W (RW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .wdata    (rec_in),
    .rd_ready (bus.rec_ready),
    .rd_valid (fifo_valid),
    .rd_data  (bus.rec_data),
    .drop     (drop)
  );

  assign bus.rec_valid = fifo_valid;
  assign drain_done    = (state == DRAIN) && !fifo_valid;
endmodule

// File: doc/ap_txn_profiler.md
Name: ap_txn_profiler

Overview:
- Synthesizable per-transaction profiler for an HLS core using the ap_ctrl_hs handshake.
- Taps the same control signals our simulation dataflow monitors sample: ap_start, ap_ready and ap_done, plus the one-hot FSM state vector.
- For each transaction it builds one record: transaction id, start cycle, latency and loop-iteration count.
- Records are buffered in a small FIFO and drained over a valid/ready stream, so on-chip runs produce the same module-status and loop-status data as the simulation CSV dumps.

Parameters:
- NUM_STATES, 6: width of the one-hot cur_state vector.
- ITER_END_IDX, 5: cur_state bit that marks the last state of a loop iteration.
- CNT_W, 32: width of the cycle counter, start cycle and latency fields.
- ITER_W, 16: width of the iteration count field.
- TXN_W, 16: width of the transaction id field.
- DEPTH, 8: number of FIFO records; must be a power of 2 and at least 2.

Ports:
- clock  in  1: sole clock.
- reset  in  1: asynchronous, active-high.
- ap_start  in  1: core start (tap).
- ap_ready  in  1: core ready (tap; checked only for protocol).
- ap_done  in  1: core done (tap).
- cur_state  in  NUM_STATES: one-hot FSM state of the core.
- finish  in  1: end of run; stop capturing and drain.
- rec_valid  out  1: a record is available.
- rec_ready  in  1: consumer accepts the record.
- rec_data  out  TXN_W+2*CNT_W+ITER_W: record packed as {txn_id, start_cycle, latency, iters}, MSB first.
- overflow  out  1: sticky; at least one record was dropped.
- proto_err  out  1: sticky; handshake violation seen.
- busy  out  1: a transaction is in flight.
- drain_done  out  1: finish has been seen and the FIFO is empty.

Behaviour:
Reset:
- Asynchronous assertion clears everything immediately, including mid-transaction.
- Cleared state: FSM in IDLE, cycle_cnt=0, txn_id=0, FIFO empty.
- All outputs read 0.
- An in-flight transaction at reset is lost and produces no record.

Cycle counter:
- cycle_cnt increments every clock after reset deasserts; the first post-reset edge has cycle_cnt=0.
- Wraps modulo 2^CNT_W.

Latency and iteration arithmetic:
- latency = (done_cycle - start_cycle + 1) mod 2^CNT_W, so a start and done in the same cycle gives latency 1.
- iters counts rising edges of cur_state[ITER_END_IDX], detected against a registered copy of that bit.
- iters saturates at 2^ITER_W-1.

Capture FSM states: IDLE, RUN, DRAIN.
- IDLE, ap_start=1: latch start_cycle=cycle_cnt, clear iters, go to RUN; busy=1 from the next cycle.
- IDLE, ap_start=1 and ap_done=1 in the same cycle: push a record with latency 1 and stay in IDLE.
- IDLE, ap_done=1 without ap_start: set proto_err; no record.
- RUN, ap_done=1: push a record and increment txn_id (wraps).
  - If ap_start=1 in that same cycle, the next transaction's start_cycle is cycle_cnt+1 and the FSM stays in RUN.
  - Otherwise go to IDLE.
- RUN, ap_ready=1 with ap_start=0: set proto_err.
- Any state, finish=1: go to DRAIN. An in-flight RUN transaction is discarded. finish has priority over an ap_done in the same cycle.
- DRAIN: absorbing until reset; no captures.
- drain_done = (state==DRAIN) and FIFO empty.

FIFO and output stream:
- First-word-fall-through; rec_valid = not empty.
- Push-to-rec_valid latency is 1 cycle.
- A pop occurs when rec_valid and rec_ready are both high; rec_data holds stable while rec_valid=1 and rec_ready=0.
- A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- A rejected push sets overflow; txn_id still increments, so gaps in txn_id identify the lost records.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

Decomposition:
- Package ap_prof_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a packed struct prof_rec_t {txn_id, start_cycle, latency, iters};
  - a localparam REC_W.
- Sub-module ap_prof_fifo: parameterized on DEPTH and REC_W; implements first-word-fall-through with simultaneous push/pop.
- Capture FSM and counters stay in the top module.

Test Plan:
1. Single transaction: ap_start pulse at cycle_cnt=10; four rising edges of cur_state[5]; ap_done at cycle_cnt=30 -> one record {0,10,21,4}; busy high for cycles 11..30.
2. Back-to-back: ap_start held, ap_done at 20 and 35 -> records {0,s,...} and {1,21,15,n}; FSM never visits IDLE.
3. Overflow: rec_ready=0, ten 5-cycle transactions -> FIFO holds txn 0..7; overflow=1 after the 9th done; draining yields exactly 8 records.
4. Full with pop: FIFO full, ap_done coincides with rec_ready=1 -> push accepted, overflow stays 0, new record appears last in order.
5. finish mid-RUN: finish=1 while busy, 3 records queued -> no new record; drain_done rises in the cycle after the 3rd pop and holds.
6. Async reset mid-RUN: reset pulse away from a clock edge -> all outputs 0 immediately; the next transaction reports txn_id 0 and start_cycle relative to the new cycle_cnt=0.
7. Protocol errors: ap_done in IDLE -> proto_err=1 and no record; proto_err holds until reset.
